pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 44 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
//   Shared definitions for the 5-stage pipeline stall/flush sequencer:
//   controller state encodings, default widths/limits, the stage-control
//   bundle type and a helper that builds the "everything advances" bundle.
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    localparam int DEF_REG_W       = 5;   // register-index width
    localparam int DEF_MEM_TIMEOUT = 15;  // MEM_WAIT cycles without ack before ERROR
    localparam int DEF_CNT_W       = 4;   // timeout counter width, 2**CNT_W > MEM_TIMEOUT
    localparam int PERF_W          = 16;  // stall performance counter width

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } ctrl_state_e;

    // Load enables and flushes for the PC and the four stage registers.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } stage_ctrl_t;

    // All stages advance; optionally squash the IF/ID and ID/EX contents.
    function automatic stage_ctrl_t ctrl_all_en(input logic flush);
        stage_ctrl_t c;
        c.pc_en      = 1'b1;
        c.ifid_en    = 1'b1;
        c.idex_en    = 1'b1;
        c.exmem_en   = 1'b1;
        c.memwb_en   = 1'b1;
        c.ifid_flush = flush;
        c.idex_flush = flush;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
//   Purely combinational load-use hazard compare between the instruction in
//   ID and a load in EX. Also reused by the forwarding unit.
// Ports
//   idRs, idRt   in  REG_W  source registers of the ID instruction
//   idUsesRt     in  1      ID instruction actually reads rt
//   exWriteReg   in  REG_W  destination register of the EX instruction
//   exMemRead    in  1      EX instruction is a load
//   exRegWrite   in  1      EX instruction writes a register
//   hit_o        out 1      ID needs the load result that is not yet available
// -----------------------------------------------------------------------------
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUsesRt,
    input  logic [REG_W-1:0] exWriteReg,
    input  logic             exMemRead,
    input  logic             exRegWrite,
    output logic             hit_o
);

    logic dest_valid;
    logic rs_match;
    logic rt_match;

    // $zero is never a real dependency, so a load targeting r0 cannot stall.
    assign dest_valid = exMemRead && exRegWrite && (exWriteReg != '0);
    assign rs_match   = (exWriteReg == idRs);
    assign rt_match   = idUsesRt && (exWriteReg == idRt);
    assign hit_o      = dest_valid && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Freezes the pipe
//   while the data memory completes a req/ack handshake, inserts load-use
//   bubbles and squashes wrong-path instructions on a taken branch.
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   idRs, idRt, idUsesRt             ID source operands
//   exWriteReg, exMemRead, exRegWrite EX destination / load info
//   exBranchTaken                    branch resolved taken in EX
//   memAccess                        MEM stage holds a load or store
//   dmemAck                          one-cycle memory completion pulse
//   dmemReq                          registered memory request
//   pcEn..memwbEn                    stage-register load enables
//   ifidFlush, idexFlush             bubble insertion on next update
//   memErr                           sticky memory timeout error
//   stallCount                       saturating count of cycles with pcEn==0
// Enables/flushes are combinational from state + inputs and are forced low
// while rst_n is asserted.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W       = DEF_REG_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W      // must satisfy 2**CNT_W > MEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  idRs,
    input  logic [REG_W-1:0]  idRt,
    input  logic              idUsesRt,
    input  logic [REG_W-1:0]  exWriteReg,
    input  logic              exMemRead,
    input  logic              exRegWrite,
    input  logic              exBranchTaken,
    input  logic              memAccess,
    input  logic              dmemAck,
    output logic              dmemReq,
    output logic              pcEn,
    output logic              ifidEn,
    output logic              idexEn,
    output logic              exmemEn,
    output logic              memwbEn,
    output logic              ifidFlush,
    output logic              idexFlush,
    output logic              memErr,
    output logic [PERF_W-1:0] stallCount
);

    ctrl_state_e       state_q, state_d;
    logic              served_q, served_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              err_q, err_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    stage_ctrl_t       ctrl;
    logic              lu_hit;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .idRs       (idRs),
        .idRt       (idRt),
        .idUsesRt   (idUsesRt),
        .exWriteReg (exWriteReg),
        .exMemRead  (exMemRead),
        .exRegWrite (exRegWrite),
        .hit_o      (lu_hit)
    );

    always_comb begin
        ctrl     = '0;          // default: everything frozen, no bubbles
        state_d  = state_q;
        served_d = served_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        err_d    = err_q;

        case (state_q)
            ST_RUN: begin
                if (memAccess && !served_q) begin
                    // Freeze already this cycle; the request goes out registered.
                    state_d = ST_MEM_WAIT;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                end else if (exBranchTaken) begin
                    // Squashing ID makes any concurrent load-use hazard moot.
                    ctrl = ctrl_all_en(1'b1);
                end else if (lu_hit) begin
                    // Hold PC and IF/ID, push a bubble into EX, let the load move on.
                    ctrl.idex_en    = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    ctrl.exmem_en   = 1'b1;
                    ctrl.memwb_en   = 1'b1;
                end else begin
                    ctrl = ctrl_all_en(1'b0);
                end
                // Once the served instruction leaves MEM the next one may request.
                if (ctrl.exmem_en) begin
                    served_d = 1'b0;
                end
            end
            ST_MEM_WAIT: begin
                // cnt_d is the number of MEM_WAIT cycles spent including this one.
                cnt_d = cnt_q + 1'b1;
                if (dmemAck) begin
                    state_d  = ST_RUN;
                    req_d    = 1'b0;
                    served_d = 1'b1;
                end else if (cnt_d == CNT_W'(MEM_TIMEOUT)) begin
                    state_d = ST_ERROR;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end
            end
            ST_ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                // Unused encoding: park in ERROR rather than run with bad state.
                state_d = ST_ERROR;
                req_d   = 1'b0;
                err_d   = 1'b1;
            end
        endcase

        if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            served_q    <= 1'b0;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            served_q    <= served_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset forces every stage register to hold with no bubble.
    assign pcEn       = rst_n & ctrl.pc_en;
    assign ifidEn     = rst_n & ctrl.ifid_en;
    assign idexEn     = rst_n & ctrl.idex_en;
    assign exmemEn    = rst_n & ctrl.exmem_en;
    assign memwbEn    = rst_n & ctrl.memwb_en;
    assign ifidFlush  = rst_n & ctrl.ifid_flush;
    assign idexFlush  = rst_n & ctrl.idex_flush;
    assign dmemReq    = req_q;
    assign memErr     = err_q;
    assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  idRs = '0, idRt = '0, exWriteReg = '0;
    logic        idUsesRt = 1'b0, exMemRead = 1'b0, exRegWrite = 1'b0;
    logic        exBranchTaken = 1'b0, memAccess = 1'b0, dmemAck = 1'b0;
    logic        dmemReq, pcEn, ifidEn, idexEn, exmemEn, memwbEn;
    logic        ifidFlush, idexFlush, memErr;
    logic [15:0] stallCount;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .idRs          (idRs),
        .idRt          (idRt),
        .idUsesRt      (idUsesRt),
        .exWriteReg    (exWriteReg),
        .exMemRead     (exMemRead),
        .exRegWrite    (exRegWrite),
        .exBranchTaken (exBranchTaken),
        .memAccess     (memAccess),
        .dmemAck       (dmemAck),
        .dmemReq       (dmemReq),
        .pcEn          (pcEn),
        .ifidEn        (ifidEn),
        .idexEn        (idexEn),
        .exmemEn       (exmemEn),
        .memwbEn       (memwbEn),
        .ifidFlush     (ifidFlush),
        .idexFlush     (idexFlush),
        .memErr        (memErr),
        .stallCount    (stallCount)
    );

    // Expected-value encodings: en = {pc, ifid, idex, exmem, memwb}, fl = {ifid, idex}
    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_LU   = 5'b00111;
    localparam logic [1:0] FL_NONE = 2'b00;
    localparam logic [1:0] FL_BR   = 2'b11;
    localparam logic [1:0] FL_LU   = 2'b01;

    typedef struct packed {
        logic [8:0]  ctl;    // {en[4:0], fl[1:0], dmemReq, memErr}
        logic [15:0] stall;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_stall = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t       e;
        string      t;
        logic [8:0] obs_ctl;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            obs_ctl = {pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush, dmemReq, memErr};
            check_eq({t, "/ctl"}, {23'd0, obs_ctl}, {23'd0, e.ctl});
            check_eq({t, "/stall"}, {16'd0, stallCount}, {16'd0, e.stall});
            $display("txn %-10s ctl=%b stall=%04h", t, obs_ctl, stallCount);
        end
    end

    // One cycle: inputs already driven; push expectation, let it be compared, advance.
    task automatic step(input string tag, input logic [4:0] en, input logic [1:0] fl,
                        input logic req, input logic err);
        exp_t e;
        if (!rst_n) exp_stall = 16'd0;
        e.ctl   = {en, fl, req, err};
        e.stall = exp_stall;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        @(posedge clk);
        #1;
        // stallCount counts cycles with pcEn==0 outside reset, saturating.
        if (rst_n && !en[4] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    endtask

    task automatic idle_inputs();
        idRs = '0; idRt = '0; idUsesRt = 1'b0; exWriteReg = '0;
        exMemRead = 1'b0; exRegWrite = 1'b0; exBranchTaken = 1'b0;
        memAccess = 1'b0; dmemAck = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses_rt);
        exMemRead = 1'b1; exRegWrite = 1'b1; exWriteReg = wr;
        idRs = rs; idRt = rt; idUsesRt = uses_rt;
    endtask

    initial begin
        int n_skip;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;

        // 1. reset override, then idle run
        step("rst0", EN_NONE, FL_NONE, 1'b0, 1'b0);
        step("rst1", EN_NONE, FL_NONE, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("idle0", EN_ALL, FL_NONE, 1'b0, 1'b0);
        step("idle1", EN_ALL, FL_NONE, 1'b0, 1'b0);

        // 2. memory handshake, ack in the third MEM_WAIT cycle
        memAccess = 1'b1;
        step("mem_run", EN_NONE, FL_NONE, 1'b0, 1'b0);
        step("mem_w1", EN_NONE, FL_NONE, 1'b1, 1'b0);
        step("mem_w2", EN_NONE, FL_NONE, 1'b1, 1'b0);
        dmemAck = 1'b1;
        step("mem_ack", EN_NONE, FL_NONE, 1'b1, 1'b0);
        dmemAck = 1'b0;
        step("mem_adv", EN_ALL, FL_NONE, 1'b0, 1'b0);   // served: no second request
        memAccess = 1'b0;
        step("mem_done", EN_ALL, FL_NONE, 1'b0, 1'b0);

        // 3. load-use via rs, r0 destination, rt with and without idUsesRt
        set_lu(5'd8, 5'd8, 5'd0, 1'b0);
        step("lu_rs", EN_LU, FL_LU, 1'b0, 1'b0);
        idle_inputs();
        step("lu_after", EN_ALL, FL_NONE, 1'b0, 1'b0);
        set_lu(5'd0, 5'd0, 5'd0, 1'b1);
        step("lu_r0", EN_ALL, FL_NONE, 1'b0, 1'b0);
        set_lu(5'd9, 5'd3, 5'd9, 1'b1);
        step("lu_rt", EN_LU, FL_LU, 1'b0, 1'b0);
        set_lu(5'd9, 5'd3, 5'd9, 1'b0);
        step("lu_nort", EN_ALL, FL_NONE, 1'b0, 1'b0);
        set_lu(5'd8, 5'd8, 5'd0, 1'b0);
        exRegWrite = 1'b0;
        step("lu_nowr", EN_ALL, FL_NONE, 1'b0, 1'b0);
        idle_inputs();

        // 4. branch beats load-use; branch and hazard held across MEM_WAIT
        set_lu(5'd8, 5'd8, 5'd0, 1'b0);
        exBranchTaken = 1'b1;
        step("br_lu", EN_ALL, FL_BR, 1'b0, 1'b0);
        idle_inputs();
        exBranchTaken = 1'b1; memAccess = 1'b1;
        step("brm_run", EN_NONE, FL_NONE, 1'b0, 1'b0);
        step("brm_w1", EN_NONE, FL_NONE, 1'b1, 1'b0);
        dmemAck = 1'b1;
        step("brm_ack", EN_NONE, FL_NONE, 1'b1, 1'b0);
        dmemAck = 1'b0;
        step("brm_defer", EN_ALL, FL_BR, 1'b0, 1'b0);
        idle_inputs();
        set_lu(5'd7, 5'd7, 5'd0, 1'b0); memAccess = 1'b1;
        step("lum_run", EN_NONE, FL_NONE, 1'b0, 1'b0);
        dmemAck = 1'b1;
        step("lum_ack", EN_NONE, FL_NONE, 1'b1, 1'b0);
        dmemAck = 1'b0;
        step("lum_defer", EN_LU, FL_LU, 1'b0, 1'b0);
        idle_inputs();
        step("idle2", EN_ALL, FL_NONE, 1'b0, 1'b0);

        // ack in the 15th MEM_WAIT cycle wins over the timeout
        memAccess = 1'b1;
        step("tw_run", EN_NONE, FL_NONE, 1'b0, 1'b0);
        for (int i = 1; i <= 14; i++) step("tw_wait", EN_NONE, FL_NONE, 1'b1, 1'b0);
        dmemAck = 1'b1;
        step("tw_ack15", EN_NONE, FL_NONE, 1'b1, 1'b0);
        dmemAck = 1'b0;
        step("tw_adv", EN_ALL, FL_NONE, 1'b0, 1'b0);
        memAccess = 1'b0;
        step("idle3", EN_ALL, FL_NONE, 1'b0, 1'b0);

        // 5. no ack for 15 MEM_WAIT cycles -> ERROR, late ack ignored
        memAccess = 1'b1;
        step("to_run", EN_NONE, FL_NONE, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) step("to_wait", EN_NONE, FL_NONE, 1'b1, 1'b0);
        step("err0", EN_NONE, FL_NONE, 1'b0, 1'b1);
        dmemAck = 1'b1;
        step("err_ack", EN_NONE, FL_NONE, 1'b0, 1'b1);
        dmemAck = 1'b0; memAccess = 1'b0;
        step("err_idle", EN_NONE, FL_NONE, 1'b0, 1'b1);

        // 6. stall counter saturation: ERROR stalls every cycle
        n_skip = 32'(16'hFFFE - exp_stall);
        repeat (n_skip) @(posedge clk);
        #1;
        exp_stall = 16'hFFFE;
        step("sat_fffe", EN_NONE, FL_NONE, 1'b0, 1'b1);
        step("sat_ffff", EN_NONE, FL_NONE, 1'b0, 1'b1);
        step("sat_hold", EN_NONE, FL_NONE, 1'b0, 1'b1);
        step("sat_hold2", EN_NONE, FL_NONE, 1'b0, 1'b1);

        // reset pulse leaves ERROR
        rst_n = 1'b0;
        step("err_rst", EN_NONE, FL_NONE, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("post_rst", EN_ALL, FL_NONE, 1'b0, 1'b0);

        // reset mid-MEM_WAIT drops dmemReq at once, no replay afterwards
        memAccess = 1'b1;
        step("rw_run", EN_NONE, FL_NONE, 1'b0, 1'b0);
        step("rw_w1", EN_NONE, FL_NONE, 1'b1, 1'b0);
        step("rw_w2", EN_NONE, FL_NONE, 1'b1, 1'b0);
        rst_n = 1'b0;
        step("rw_rst", EN_NONE, FL_NONE, 1'b0, 1'b0);
        rst_n = 1'b1; memAccess = 1'b0;
        step("rw_after", EN_ALL, FL_NONE, 1'b0, 1'b0);
        step("rw_after2", EN_ALL, FL_NONE, 1'b0, 1'b0);

        check_eq("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
